// File: rtl/attack_round_if.sv
// Signal bundle between the game top level and the attack_round turn controller.
interface attack_round_if;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [3:0]  state_in;
  logic [1:0]  rotate_in;
  logic        busy_out;
  logic        finished_out;
  logic [7:0]  damage_out;
  logic        hp_dec_out;
  logic [11:0] pixel_out;

  modport master (
    output hcount_in, vcount_in, state_in, rotate_in,
    input  busy_out, finished_out, damage_out, hp_dec_out, pixel_out
  );

  modport slave (
    input  hcount_in, vcount_in, state_in, rotate_in,
    output busy_out, finished_out, damage_out, hp_dec_out, pixel_out
  );
endinterface

// File: rtl/attack_round.sv
// Player attack turn: sweeps a bar across the battle frame, scores the swipe,
// drains enemy health, flashes, then shrinks and raises the frame.
module attack_round #(
  parameter int         FRAME_X      = 128,
  parameter int         FRAME_Y      = 384,
  parameter int         FRAME_W      = 768,
  parameter int         FRAME_H      = 192,
  parameter int         BORDER       = 8,
  parameter int         BAR_W        = 8,
  parameter int         BAR_H        = 160,
  parameter int         BAR_STEP     = 8,
  parameter int         MAX_DAMAGE   = 24,
  parameter int         DMG_SHIFT    = 4,
  parameter int         HOLD_FRAMES  = 60,
  parameter int         FLASH_PERIOD = 10,
  parameter int         SHRINK_W     = 160,
  parameter int         SHRINK_STEP  = 4,
  parameter int         RISE_DY      = 80,
  parameter int         RISE_STEP    = 8,
  parameter logic [3:0] START_STATE  = 4'b0001
) (
  input  logic           clk,
  input  logic           rst,
  attack_round_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_SWEEP, S_DRAIN, S_FLASH, S_SHRINK, S_RISE, S_DONE
  } state_t;

  localparam logic [10:0] BAR_LIMIT = 11'(FRAME_X + FRAME_W - BORDER - BAR_W);
  localparam logic [9:0]  Y_TOP     = 10'(FRAME_Y - RISE_DY);

  state_t      state_r, state_s;
  logic [10:0] x_r, x_s, w_r, w_s, bar_r, bar_s;
  logic [9:0]  y_r, y_s;
  logic [11:0] colour_r, colour_s, pixel_r, pixel_s;
  logic [7:0]  rem_r, rem_s, flash_cnt_r, flash_cnt_s, period_r, period_s;
  logic [7:0]  damage_r, damage_s, hit_dmg_s;
  logic        hp_r, hp_s, busy_r, busy_s, fin_r, fin_s;
  logic [3:0]  prev_r;
  logic        tick_s, start_s, busy_now_s, bar_vis_s;
  logic [10:0] bar_adv_s, w_dec_s;
  logic [9:0]  y_dec_s;
  logic [11:0] h_s, v_s, xl_s, xr_s, yt_s, yb_s, by_s;
  logic        in_outer_s, in_inner_s, in_bar_s;

  // Damage from distance between bar centre and frame centre.
  function automatic logic [7:0] calc_damage(input logic [10:0] bar);
    logic [11:0] c, r, e, pen;
    c   = {1'b0, bar} + 12'(BAR_W / 2);
    r   = 12'(FRAME_X + FRAME_W / 2);
    e   = (c >= r) ? (c - r) : (r - c);
    pen = e >> DMG_SHIFT;
    return (pen >= 12'(MAX_DAMAGE)) ? 8'd0 : 8'(12'(MAX_DAMAGE) - pen);
  endfunction

  // Next-state, datapath and pixel logic.
  always_comb begin
    state_s     = state_r;
    x_s         = x_r;
    y_s         = y_r;
    w_s         = w_r;
    bar_s       = bar_r;
    colour_s    = colour_r;
    rem_s       = rem_r;
    flash_cnt_s = flash_cnt_r;
    period_s    = period_r;
    damage_s    = damage_r;
    hp_s        = 1'b0;
    tick_s      = (bus.hcount_in == 11'd0) && (bus.vcount_in == 10'd0);
    start_s     = (bus.state_in == START_STATE) && (prev_r != START_STATE) &&
                  ((state_r == S_IDLE) || (state_r == S_DONE));
    bar_adv_s   = bar_r + 11'(BAR_STEP);
    w_dec_s     = w_r - 11'(2 * SHRINK_STEP);
    y_dec_s     = y_r - 10'(RISE_STEP);
    hit_dmg_s   = calc_damage(bar_r);

    case (state_r)
      S_IDLE, S_DONE: begin
        if (start_s) begin
          x_s         = 11'(FRAME_X);
          y_s         = 10'(FRAME_Y);
          w_s         = 11'(FRAME_W);
          bar_s       = 11'(FRAME_X + BORDER);
          colour_s    = 12'hFFF;
          rem_s       = 8'd0;
          flash_cnt_s = 8'd0;
          period_s    = 8'd0;
          state_s     = S_ARM;
        end else begin
          state_s = state_r;
        end
      end
      S_ARM: begin
        if (tick_s) begin
          bar_s = bar_adv_s;
        end else begin
          bar_s = bar_r;
        end
        if (tick_s && (bar_adv_s >= BAR_LIMIT)) begin
          damage_s = 8'd0;
          state_s  = S_SHRINK;
        end else if (bus.rotate_in == 2'b00) begin
          state_s = S_SWEEP;
        end else begin
          state_s = S_ARM;
        end
      end
      S_SWEEP: begin
        // A swipe on a tick cycle scores the bar before it advances.
        if (bus.rotate_in == 2'b01) begin
          damage_s = hit_dmg_s;
          rem_s    = hit_dmg_s;
          state_s  = (hit_dmg_s == 8'd0) ? S_FLASH : S_DRAIN;
        end else if (tick_s) begin
          bar_s = bar_adv_s;
          if (bar_adv_s >= BAR_LIMIT) begin
            damage_s = 8'd0;
            state_s  = S_SHRINK;
          end else begin
            state_s = S_SWEEP;
          end
        end else begin
          state_s = S_SWEEP;
        end
      end
      S_DRAIN: begin
        if (rem_r == 8'd0) begin
          state_s = S_FLASH;
        end else if (tick_s) begin
          hp_s    = 1'b1;
          rem_s   = rem_r - 8'd1;
          state_s = (rem_r == 8'd1) ? S_FLASH : S_DRAIN;
        end else begin
          state_s = S_DRAIN;
        end
      end
      S_FLASH: begin
        if (tick_s) begin
          if (period_r == 8'(FLASH_PERIOD - 1)) begin
            period_s = 8'd0;
            colour_s = ~colour_r;
          end else begin
            period_s = period_r + 8'd1;
          end
          if (flash_cnt_r == 8'(HOLD_FRAMES - 1)) begin
            state_s = S_SHRINK;
          end else begin
            flash_cnt_s = flash_cnt_r + 8'd1;
          end
        end else begin
          state_s = S_FLASH;
        end
      end
      S_SHRINK: begin
        if (tick_s) begin
          x_s     = x_r + 11'(SHRINK_STEP);
          w_s     = w_dec_s;
          state_s = (w_dec_s == 11'(SHRINK_W)) ? S_RISE : S_SHRINK;
        end else begin
          state_s = S_SHRINK;
        end
      end
      S_RISE: begin
        if (tick_s) begin
          y_s     = y_dec_s;
          state_s = (y_dec_s == Y_TOP) ? S_DONE : S_RISE;
        end else begin
          state_s = S_RISE;
        end
      end
      default: state_s = S_IDLE;
    endcase

    busy_s = (state_s != S_IDLE) && (state_s != S_DONE);
    fin_s  = (state_s == S_DONE) && (bus.state_in == START_STATE);

    busy_now_s = (state_r != S_IDLE) && (state_r != S_DONE);
    bar_vis_s  = (state_r == S_ARM) || (state_r == S_SWEEP) ||
                 (state_r == S_DRAIN) || (state_r == S_FLASH);
    h_s  = {1'b0, bus.hcount_in};
    v_s  = {2'b00, bus.vcount_in};
    xl_s = {1'b0, x_r};
    xr_s = xl_s + {1'b0, w_r};
    yt_s = {2'b00, y_r};
    yb_s = yt_s + 12'(FRAME_H);
    by_s = yt_s + 12'(2 * BORDER);
    in_outer_s = (h_s >= xl_s) && (h_s < xr_s) && (v_s >= yt_s) && (v_s < yb_s);
    in_inner_s = (h_s >= xl_s + 12'(BORDER)) && (h_s < xr_s - 12'(BORDER)) &&
                 (v_s >= yt_s + 12'(BORDER)) && (v_s < yb_s - 12'(BORDER));
    in_bar_s   = (h_s >= {1'b0, bar_r}) && (h_s < {1'b0, bar_r} + 12'(BAR_W)) &&
                 (v_s >= by_s) && (v_s < by_s + 12'(BAR_H));
    if (!busy_now_s) begin
      pixel_s = 12'h000;
    end else if (bar_vis_s && in_bar_s) begin
      pixel_s = colour_r;
    end else if (in_outer_s && !in_inner_s) begin
      pixel_s = 12'hFFF;
    end else begin
      pixel_s = 12'h000;
    end
  end

  // State, geometry and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      x_r         <= 11'(FRAME_X);
      y_r         <= 10'(FRAME_Y);
      w_r         <= 11'(FRAME_W);
      bar_r       <= 11'(FRAME_X + BORDER);
      colour_r    <= 12'hFFF;
      rem_r       <= 8'd0;
      flash_cnt_r <= 8'd0;
      period_r    <= 8'd0;
      damage_r    <= 8'd0;
      hp_r        <= 1'b0;
      busy_r      <= 1'b0;
      fin_r       <= 1'b0;
      pixel_r     <= 12'h000;
      prev_r      <= 4'd0;
    end else begin
      state_r     <= state_s;
      x_r         <= x_s;
      y_r         <= y_s;
      w_r         <= w_s;
      bar_r       <= bar_s;
      colour_r    <= colour_s;
      rem_r       <= rem_s;
      flash_cnt_r <= flash_cnt_s;
      period_r    <= period_s;
      damage_r    <= damage_s;
      hp_r        <= hp_s;
      busy_r      <= busy_s;
      fin_r       <= fin_s;
      pixel_r     <= pixel_s;
      prev_r      <= bus.state_in;
    end
  end

  assign bus.busy_out     = busy_r;
  assign bus.finished_out = fin_r;
  assign bus.damage_out   = damage_r;
  assign bus.hp_dec_out   = hp_r;
  assign bus.pixel_out    = pixel_r;

endmodule
